// File: rtl/rc4_pkg.sv
// Shared constants and types for the key-search message checker.
// Character bounds, default message length and checker FSM states.
package rc4_pkg;

  localparam logic [7:0] CHAR_LOW_A = 8'h61;
  localparam logic [7:0] CHAR_LOW_Z = 8'h7A;
  localparam logic [7:0] CHAR_SPACE = 8'h20;

  localparam int MSG_LEN_DEF = 32;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    EVAL,
    DONE
  } checker_state_t;

endpackage

// File: rtl/char_is_legal.sv
// Flags a byte as legal when it is lowercase a..z or space.
// Ports: data (DATA_W char in), legal (1 = acceptable char).
module char_is_legal
  import rc4_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] data,
  output logic              legal
);

  logic is_lower;
  logic is_space;

  assign is_lower = (data >= DATA_W'(CHAR_LOW_A))
                 && (data <= DATA_W'(CHAR_LOW_Z));
  assign is_space = (data == DATA_W'(CHAR_SPACE));
  assign legal    = is_lower | is_space;

endmodule

// File: rtl/message_checker.sv
// Scans the decrypted-message RAM and reports whether all bytes are legal.
// Ports: clk, reset, start/finish/valid handshake, ram_addr/ram_rdata, fail_addr.
module message_checker
  import rc4_pkg::*;
#(
  parameter int MSG_LEN = MSG_LEN_DEF,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              finish,
  output logic              valid,
  output logic [ADDR_W-1:0] fail_addr
);

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(MSG_LEN - 1);

  checker_state_t    state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] fail_q, fail_d;
  logic              valid_q, valid_d;
  logic              legal;

  char_is_legal #(
    .DATA_W(DATA_W)
  ) u_legal (
    .data (ram_rdata),
    .legal(legal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      fail_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      fail_q  <= fail_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    fail_d  = fail_q;
    valid_d = valid_q;
    unique case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (start) begin
          addr_d  = '0;
          fail_d  = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (!start) begin
          addr_d  = '0;
          state_d = IDLE;
        end else begin
          state_d = EVAL;
        end
      end
      EVAL: begin
        // Dropping start abandons the scan before any verdict lands.
        if (!start) begin
          addr_d  = '0;
          state_d = IDLE;
        end else if (!legal) begin
          fail_d  = addr_q;
          valid_d = 1'b0;
          state_d = DONE;
        end else if (addr_q == LAST) begin
          valid_d = 1'b1;
          state_d = DONE;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = FETCH;
        end
      end
      DONE: begin
        if (!start) begin
          valid_d = 1'b0;
          addr_d  = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ram_addr  = addr_q;
  assign fail_addr = fail_q;
  assign valid     = valid_q;
  assign finish    = (state_q == DONE);

endmodule

// File: doc/message_checker.md
Name: message_checker

Overview:
- Responder end of the key-search handshake. Takes a level-held check request from the brute-force controller.
- Scans the decrypted-message RAM one byte at a time and returns a done flag plus a verdict.
- A message is valid when every byte is lowercase 'a'..'z' or space.
- Sits between the decrypted-message RAM read port and the controller's check_start, check_finish and check_valid signals.

Parameters:
- MSG_LEN, 32, number of message bytes to scan (addresses 0..MSG_LEN-1).
- ADDR_W, 5, RAM address width; must satisfy 2**ADDR_W >= MSG_LEN.
- DATA_W, 8, RAM data width (one character).

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  check request from controller, level-held until finish is seen
- ram_addr  out  ADDR_W  read address to decrypted-message RAM
- ram_rdata  in  DATA_W  RAM read data, valid one cycle after ram_addr is registered
- finish  out  1  scan complete; held while start stays high
- valid  out  1  verdict, 1 = all bytes legal; meaningful only while finish=1
- fail_addr  out  ADDR_W  address of first illegal byte; meaningful when finish=1 and valid=0

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset values: state IDLE, ram_addr=0, finish=0, valid=0, fail_addr=0. Reset mid-scan or in DONE returns to IDLE on the next edge, overriding start.
- Legal byte: 8'h61 <= b <= 8'h7A, or b == 8'h20. All other values are illegal, including uppercase, digits, 8'h00 and 8'hFF.
- States:
  - IDLE: finish=0, valid=0. If start=1, set ram_addr=0 and go to FETCH.
  - FETCH: wait one cycle for RAM read latency, then go to EVAL.
  - EVAL: evaluate ram_rdata.
    - Illegal byte: set fail_addr=ram_addr, valid=0, go to DONE (early exit).
    - Legal byte and ram_addr==MSG_LEN-1: set valid=1, go to DONE.
    - Otherwise: increment ram_addr, go to FETCH.
  - DONE: finish=1, valid and fail_addr held. When start=0, go to IDLE; finish and valid clear on that edge.
- Throughput: 2 cycles per byte. Call the edge that samples start in IDLE edge 0.
  - Byte k is evaluated at edge 2k+2.
  - All-legal message: finish rises after edge 2*MSG_LEN (edge 64 at default).
  - First illegal byte at index k: finish rises after edge 2k+2.
- Handshake is four-phase: start high -> finish high -> start low -> finish low. A new scan cannot begin until the block has passed through IDLE (finish low for at least one cycle).
- If start drops while in FETCH or EVAL: abort to IDLE with no finish pulse. Verdict is discarded and ram_addr resets to 0.
- ram_addr never exceeds MSG_LEN-1 and never wraps.
- When start rises in the same cycle that DONE exits to IDLE, the scan begins on the following edge. Every scan starts from address 0 with fresh state.

Decomposition:
- Package rc4_pkg:
  - CHAR_LOW_A=8'h61, CHAR_LOW_Z=8'h7A, CHAR_SPACE=8'h20.
  - MSG_LEN default.
  - state enum for checker_state_t (IDLE, FETCH, EVAL, DONE).
- Sub-module char_is_legal: purely combinational, DATA_W-bit input, 1-bit legal output, shared with any future per-byte filters.
- FSM, address counter and verdict registers live in message_checker.

Test Plan:
- All-legal: RAM holds "the quick brown fox jumps over t" (32 bytes). Raise start at edge 0 -> finish=1 and valid=1 after edge 64; ram_addr sweeps 0..31 once.
- Early fail: byte 5 = 8'h41 ('A'), rest legal -> finish=1, valid=0, fail_addr=5 after edge 12; ram_addr never exceeds 5.
- Boundaries: byte 0 = 8'h60 -> finish after edge 2, valid=0, fail_addr=0. Byte 31 = 8'h7B -> fail_addr=31 at edge 64. Separately, bytes 8'h61, 8'h7A and 8'h20 only -> valid=1.
- Handshake: hold start 10 cycles after finish -> finish and valid stay constant. Drop start -> finish=0 and valid=0 next edge. Re-raise start -> fresh scan from address 0.
- Abort: drop start at edge 20 mid-scan -> IDLE, finish never asserts. Restart -> full 64-edge scan with correct verdict.
- Reset: assert reset during EVAL and during DONE -> next edge finish=0, valid=0, ram_addr=0, fail_addr=0, state IDLE, even with start held high.
